// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by the decode-stage register file.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_mux.sv
// One asynchronous read port of the register file, with optional hardwired-zero index 0.
module regfile_read_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [DATA_W-1:0] registers [2**ADDR_W],
  input  logic [ADDR_W-1:0] readReg,
  output logic [DATA_W-1:0] readData
);

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

  always_comb begin
    readData = registers[readReg];
    if (ZERO_REG && (readReg == ZeroIdx)) begin
      readData = '0;
    end
  end

endmodule

// File: rtl/dual_write_regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, two synchronous write ports.
// Port 2 wins when both ports write the same register on the same edge.
module dual_write_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              RegWrite2,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int unsigned       NumRegs = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] registers [NumRegs];

  logic writeEn1;
  logic writeEn2;

  always_comb begin
    writeEn1 = RegWrite  && !(ZERO_REG && (WriteReg1 == ZeroIdx));
    writeEn2 = RegWrite2 && !(ZERO_REG && (WriteReg2 == ZeroIdx));
  end

  // Port 2 is assigned last so it takes priority on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        registers[i] <= '0;
      end
    end else begin
      if (writeEn1) begin
        registers[WriteReg1] <= WriteData1;
      end
      if (writeEn2) begin
        registers[WriteReg2] <= WriteData2;
      end
    end
  end

  regfile_read_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) uReadMuxA (
    .registers(registers),
    .readReg  (ReadReg1),
    .readData (ReadData1)
  );

  regfile_read_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) uReadMuxB (
    .registers(registers),
    .readReg  (ReadReg2),
    .readData (ReadData2)
  );

endmodule

// File: tb/tb_dual_write_regfile.sv
// Scoreboard bench for dual_write_regfile: stimulus queues expected read data, a monitor compares.
module tb_dual_write_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic [4:0]  WriteReg1 = '0;
  logic [31:0] WriteData1 = '0;
  logic        RegWrite2 = 1'b0;
  logic [4:0]  WriteReg2 = '0;
  logic [31:0] WriteData2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  dual_write_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg1 (WriteReg1),
    .WriteData1(WriteData1),
    .RegWrite2 (RegWrite2),
    .WriteReg2 (WriteReg2),
    .WriteData2(WriteData2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } expect_t;

  expect_t     sbQ[$];
  logic        obsValid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  // Monitor: pops one expectation per presented observation.
  always @(posedge obsValid) begin
    expect_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: observation with empty queue");
    end else begin
      e = sbQ.pop_front();
      checks += 2;
      if (ReadData1 !== e.e1) begin
        errors++;
        $display("FAIL %s portA reg%0d: got %h expected %h", e.name, e.r1, ReadData1, e.e1);
      end
      if (ReadData2 !== e.e2) begin
        errors++;
        $display("FAIL %s portB reg%0d: got %h expected %h", e.name, e.r2, ReadData2, e.e2);
      end
    end
  end

  task automatic present(input string name, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] e1, input logic [31:0] e2);
    expect_t e;
    ReadReg1 = r1;
    ReadReg2 = r2;
    #1;
    e.name = name; e.r1 = r1; e.r2 = r2; e.e1 = e1; e.e2 = e2;
    sbQ.push_back(e);
    obsValid = 1'b1;
    #1;
    obsValid = 1'b0;
  endtask

  task automatic setWrite(input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic we2, input logic [4:0] a2, input logic [31:0] d2);
    RegWrite = we1; WriteReg1 = a1; WriteData1 = d1;
    RegWrite2 = we2; WriteReg2 = a2; WriteData2 = d2;
  endtask

  // Waits for the committing edge, drops enables, and advances the reference model.
  task automatic commit();
    @(posedge clk);
    #1;
    if (RegWrite && WriteReg1 != 5'd0) model[WriteReg1] = WriteData1;
    if (RegWrite2 && WriteReg2 != 5'd0) model[WriteReg2] = WriteData2;
    RegWrite = 1'b0;
    RegWrite2 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state while rst_n is held low.
    #2;
    present("reset_init", 5'd0, 5'd31, 32'h0, 32'h0);
    present("reset_init", 5'd7, 5'd15, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload random values through both write ports.
    @(negedge clk);
    for (int i = 1; i < 32; i += 2) begin
      setWrite(1'b1, 5'(i), $urandom, i < 31, 5'(i + 1), $urandom);
      commit();
    end
    present("preload", 5'd9, 5'd30, model[9], model[30]);

    // Asynchronous reset mid-cycle: cleared before any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 32; i++) present("async_reset", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port-2 only write.
    @(negedge clk);
    setWrite(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hFEFDFBF7);
    commit();
    present("port2_write", 5'd7, 5'd1, 32'hFEFDFBF7, 32'h0);
    present("port2_untouched", 5'd0, 5'd1, 32'h0, 32'h0);

    // Port-1 only write; the value must not bypass before the edge.
    setWrite(1'b1, 5'd2, 32'h8EFDFBF7, 1'b0, 5'd0, 32'h0);
    present("no_bypass", 5'd7, 5'd2, 32'hFEFDFBF7, 32'h0);
    commit();
    present("port1_write", 5'd7, 5'd2, 32'hFEFDFBF7, 32'h8EFDFBF7);

    // Dual write to distinct registers, then a collision on reg 5.
    setWrite(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222);
    commit();
    present("dual_write", 5'd3, 5'd4, 32'h11111111, 32'h22222222);
    setWrite(1'b1, 5'd5, 32'hAAAAAAAA, 1'b1, 5'd5, 32'h55555555);
    commit();
    present("collision", 5'd5, 5'd5, 32'h55555555, 32'h55555555);

    // Zero register ignores writes from both ports.
    setWrite(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    commit();
    present("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

    // Disabled ports with random address/data leave the array unchanged.
    for (int n = 0; n < 10; n++) begin
      setWrite(1'b0, 5'($urandom), $urandom, 1'b0, 5'($urandom), $urandom);
      commit();
    end
    for (int i = 0; i < 32; i++) present("disabled", 5'(i), 5'(31 - i), model[i], model[31 - i]);

    // Combinational read response between edges.
    present("async_read", 5'd7, 5'd3, 32'hFEFDFBF7, 32'h11111111);
    present("async_read", 5'd2, 5'd3, 32'h8EFDFBF7, 32'h11111111);
    present("async_read", 5'd4, 5'd0, 32'h22222222, 32'h0);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 100 && sbQ.size() != 0; t++) #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
